store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 32, byte address width in bits.
REQ-003 SHALL have parameter NUM_ENTRIES, default 4, FIFO depth; power of two, >= 2.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port st_valid  input  1  memory stage presents a store.
REQ-007 SHALL have port st_addr  input  ADDRESS_WIDTH  store byte address.
REQ-008 SHALL have port st_data  input  WORD_WIDTH  store data; byte store uses bits [7:0].
REQ-009 SHALL have port st_byte  input  1  1 = byte store (sb), 0 = word store (sw).
REQ-010 SHALL have port st_ready  output  1  buffer can accept a store this cycle.
REQ-011 SHALL have port ld_valid  input  1  memory stage presents a word load.
REQ-012 SHALL have port ld_addr  input  ADDRESS_WIDTH  load byte address, word-aligned.
REQ-013 SHALL have port fwd_hit  output  1  load satisfied from buffer.
REQ-014 SHALL have port fwd_data  output  WORD_WIDTH  forwarded load data.
REQ-015 SHALL have port fwd_stall  output  1  load must stall (partial overlap).
REQ-016 SHALL have port dc_req  output  1  head store presented to dcache.
REQ-017 SHALL have ports dc_addr / dc_data / dc_byte  output  ADDRESS_WIDTH / WORD_WIDTH / 1  head entry fields.
REQ-018 SHALL have port dc_ack  input  1  dcache accepted head store this cycle.
REQ-019 SHALL have ports empty, full  output  1 each; count  output  $clog2(NUM_ENTRIES)+1  occupancy.

Function
REQ-020 SHALL store entries {addr, data, byte} in a circular FIFO with head/tail pointers wrapping modulo NUM_ENTRIES.
REQ-021 SHALL assert st_ready = !full combinationally; a dequeue in the same cycle SHALL NOT make a full buffer ready.
REQ-022 SHALL enqueue at tail on rising edge when st_valid && st_ready; st_valid while full SHALL be ignored, no state change.
REQ-023 SHALL drive dc_req = !empty and dc_addr/dc_data/dc_byte from the head entry combinationally; zero when empty.
REQ-024 SHALL dequeue head on rising edge when dc_req && dc_ack; dc_ack while empty SHALL be ignored.
REQ-025 SHALL hold head outputs stable while dc_req && !dc_ack (no reordering, no drop).
REQ-026 SHALL keep count unchanged on simultaneous enqueue and dequeue; +1 on enqueue only; -1 on dequeue only.
REQ-027 SHALL assert full when count == NUM_ENTRIES, empty when count == 0.
REQ-028 SHALL perform forwarding combinationally when ld_valid, comparing ld_addr[ADDRESS_WIDTH-1:2] with every valid entry's addr[ADDRESS_WIDTH-1:2], including the head being dequeued this cycle.
REQ-029 SHALL select the youngest matching entry; if it is a word store, fwd_hit = 1, fwd_data = its data, fwd_stall = 0.
REQ-030 SHALL assert fwd_stall = 1, fwd_hit = 0 if the youngest match is a byte store.
REQ-031 SHALL drive fwd_hit = fwd_stall = 0, fwd_data = 0 on no match or ld_valid = 0.
REQ-032 SHALL NOT forward from a store being enqueued in the same cycle (searched only from the next cycle).
REQ-033 SHALL have latency: enqueued store visible on dc_req one cycle after enqueue edge if buffer was empty.

Reset
REQ-034 SHALL, on reset assertion, immediately clear head, tail, count and all entry valid bits, regardless of clk.
REQ-035 SHALL drive during reset: st_ready=1 after release (0 not required during), dc_req=0, dc_addr/dc_data/dc_byte=0, fwd_hit=0, fwd_stall=0, fwd_data=0, empty=1, full=0, count=0.
REQ-036 SHALL drop any pending/unacknowledged store on reset mid-drain; dc_req falls asynchronously.

Verification
REQ-037 Enqueue sw addr 0x0, data 0x00000002, dc_ack=0 -> next cycle dc_req=1, dc_addr=0x0, dc_data=0x2, count=1.
REQ-038 Enqueue 4 stores (0x0,0x4,0x8,0xC), no ack -> full=1, st_ready=0; 5th st_valid ignored; ack 4 times -> dc_addr order 0x0,0x4,0x8,0xC, empty=1.
REQ-039 Stores sw 0x10<-0xAAAA then sw 0x10<-0xBBBB, ld 0x10 -> fwd_hit=1, fwd_data=0x0000BBBB.
REQ-040 sw 0x20<-0x11223344 then sb 0x21<-0x55, ld 0x20 -> fwd_stall=1, fwd_hit=0.
REQ-041 Full buffer, st_valid and dc_ack same cycle -> store rejected, count 4->3; wrap: 6 enqueue/dequeue pairs keep FIFO order.
REQ-042 Two stores pending, dc_req=1, assert reset between edges -> dc_req=0, count=0 immediately; after release empty=1.

Source files
------------

// File: rtl/store_buffer.sv
// Circular store FIFO that drains to the dcache in order and forwards word loads from the youngest matching store.
// dc_req rises one cycle after a store is enqueued into an empty buffer; st_ready is !full, so a same-cycle drain does not admit a store.
module store_buffer #(
  parameter int WORD_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int NUM_ENTRIES   = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           st_valid,
  input  logic [ADDRESS_WIDTH-1:0]       st_addr,
  input  logic [WORD_WIDTH-1:0]          st_data,
  input  logic                           st_byte,
  output logic                           st_ready,
  input  logic                           ld_valid,
  input  logic [ADDRESS_WIDTH-1:0]       ld_addr,
  output logic                           fwd_hit,
  output logic [WORD_WIDTH-1:0]          fwd_data,
  output logic                           fwd_stall,
  output logic                           dc_req,
  output logic [ADDRESS_WIDTH-1:0]       dc_addr,
  output logic [WORD_WIDTH-1:0]          dc_data,
  output logic                           dc_byte,
  input  logic                           dc_ack,
  output logic                           empty,
  output logic                           full,
  output logic [$clog2(NUM_ENTRIES):0]   count
);

  localparam int PTR_W = $clog2(NUM_ENTRIES);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDRESS_WIDTH-1:0] ent_addr [NUM_ENTRIES];
  logic [WORD_WIDTH-1:0]    ent_data [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0]   ent_byte;
  logic [NUM_ENTRIES-1:0]   ent_valid;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             enq;
  logic             deq;

  logic                  match_found;
  logic                  match_byte;
  logic [WORD_WIDTH-1:0] match_data;
  logic [PTR_W-1:0]      idx;
  logic                  unused_ld_lsb;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(NUM_ENTRIES));
  assign st_ready = !full;
  assign enq      = st_valid && st_ready;
  assign dc_req   = !empty;
  assign deq      = dc_req && dc_ack;

  assign dc_addr  = empty ? '0 : ent_addr[head];
  assign dc_data  = empty ? '0 : ent_data[head];
  assign dc_byte  = !empty && ent_byte[head];

  // Loads are word-aligned, so only the word index takes part in matching.
  assign unused_ld_lsb = ^ld_addr[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      if (deq) begin
        ent_valid[head] <= 1'b0;
        head            <= head + PTR_W'(1);
      end
      if (enq) begin
        ent_valid[tail] <= 1'b1;
        tail            <= tail + PTR_W'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload needs no reset: it is only observed through valid entries.
  always_ff @(posedge clk) begin
    if (enq) begin
      ent_addr[tail] <= st_addr;
      ent_data[tail] <= st_data;
      ent_byte[tail] <= st_byte;
    end
  end

  // Walk oldest to youngest from head so the last hit is the youngest store.
  always_comb begin
    match_found = 1'b0;
    match_byte  = 1'b0;
    match_data  = '0;
    idx         = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      idx = head + PTR_W'(i);
      if (ent_valid[idx] &&
          ent_addr[idx][ADDRESS_WIDTH-1:2] == ld_addr[ADDRESS_WIDTH-1:2]) begin
        match_found = 1'b1;
        match_byte  = ent_byte[idx];
        match_data  = ent_data[idx];
      end
    end
  end

  always_comb begin
    fwd_hit   = 1'b0;
    fwd_stall = 1'b0;
    fwd_data  = '0;
    if (ld_valid && match_found) begin
      if (match_byte) begin
        fwd_stall = 1'b1;
      end else begin
        fwd_hit  = 1'b1;
        fwd_data = match_data;
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_byte;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        fwd_stall;
  logic        dc_req;
  logic [31:0] dc_addr;
  logic [31:0] dc_data;
  logic        dc_byte;
  logic        dc_ack;
  logic        empty;
  logic        full;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        b;
  } ent_t;
  ent_t sb[$];

  store_buffer dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_byte(st_byte),
    .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_stall(fwd_stall),
    .dc_req(dc_req), .dc_addr(dc_addr), .dc_data(dc_data), .dc_byte(dc_byte),
    .dc_ack(dc_ack),
    .empty(empty), .full(full), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_fwd(input string tag, input logic hit, input logic stall, input logic [31:0] data);
    chk({tag, "_hit"}, 64'(fwd_hit), 64'(hit));
    chk({tag, "_stall"}, 64'(fwd_stall), 64'(stall));
    chk({tag, "_data"}, 64'(fwd_data), 64'(data));
  endtask

  // One clock with optional store and ack; head is scored against the queue before the edge.
  task automatic tick(input logic sv, input logic [31:0] a, input logic [31:0] d,
                      input logic b, input logic ack);
    ent_t e;
    bit   enq_ok;
    bit   deq_ok;
    st_valid = sv; st_addr = a; st_data = d; st_byte = b; dc_ack = ack;
    #1;
    enq_ok = sv && (sb.size() < 4);
    deq_ok = ack && (sb.size() > 0);
    chk("st_ready", 64'(st_ready), 64'(sb.size() < 4));
    if (deq_ok) begin
      chk("dc_req", 64'(dc_req), 64'(1));
      chk("dc_addr", 64'(dc_addr), 64'(sb[0].a));
      chk("dc_data", 64'(dc_data), 64'(sb[0].d));
      chk("dc_byte", 64'(dc_byte), 64'(sb[0].b));
    end
    @(posedge clk);
    if (deq_ok) void'(sb.pop_front());
    if (enq_ok) begin
      e.a = a; e.d = d; e.b = b;
      sb.push_back(e);
    end
    #1;
    st_valid = 1'b0; dc_ack = 1'b0;
  endtask

  task automatic chk_level(input string tag);
    chk({tag, "_count"}, 64'(count), 64'(sb.size()));
    chk({tag, "_empty"}, 64'(empty), 64'(sb.size() == 0));
    chk({tag, "_full"}, 64'(full), 64'(sb.size() == 4));
  endtask

  initial begin
    reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_byte = 1'b0;
    ld_valid = 1'b0; ld_addr = '0; dc_ack = 1'b0;
    #2;
    chk("rst_empty", 64'(empty), 64'(1));
    chk("rst_full", 64'(full), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_dc_req", 64'(dc_req), 64'(0));
    chk("rst_dc_addr", 64'(dc_addr), 64'(0));
    chk_fwd("rst_fwd", 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rel_st_ready", 64'(st_ready), 64'(1));

    // First store appears at the dcache port one cycle after enqueue.
    tick(1'b1, 32'h0, 32'h2, 1'b0, 1'b0);
    chk("lat_dc_req", 64'(dc_req), 64'(1));
    chk("lat_dc_addr", 64'(dc_addr), 64'(0));
    chk("lat_dc_data", 64'(dc_data), 64'(2));
    chk_level("lat");

    // Fill, reject an overflow store, then drain in order.
    tick(1'b1, 32'h4, 32'h104, 1'b0, 1'b0);
    tick(1'b1, 32'h8, 32'h108, 1'b0, 1'b0);
    tick(1'b1, 32'hC, 32'h10C, 1'b0, 1'b0);
    chk_level("fill");
    chk("fill_st_ready", 64'(st_ready), 64'(0));
    tick(1'b1, 32'h40, 32'hDEAD, 1'b0, 1'b0);
    chk_level("ovf");
    for (int i = 0; i < 4; i++) tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk_level("drain");
    chk("drain_dc_addr", 64'(dc_addr), 64'(0));
    tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk_level("ack_empty");

    // Youngest word store wins; a same-cycle store is not yet searchable.
    tick(1'b1, 32'h10, 32'hAAAA, 1'b0, 1'b0);
    tick(1'b1, 32'h10, 32'hBBBB, 1'b0, 1'b0);
    ld_valid = 1'b1; ld_addr = 32'h10; #1;
    chk_fwd("fwd_young", 1'b1, 1'b0, 32'h0000BBBB);
    ld_addr = 32'h14;
    st_valid = 1'b1; st_addr = 32'h14; st_data = 32'hCCCC; st_byte = 1'b0; #1;
    chk_fwd("fwd_same_cyc", 1'b0, 1'b0, 32'h0);
    tick(1'b1, 32'h14, 32'hCCCC, 1'b0, 1'b0);
    chk_fwd("fwd_next_cyc", 1'b1, 1'b0, 32'h0000CCCC);
    ld_valid = 1'b0; #1;
    chk_fwd("fwd_ld_off", 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk_level("fwd_drain");

    // Byte store over a word store forces a stall.
    tick(1'b1, 32'h20, 32'h11223344, 1'b0, 1'b0);
    tick(1'b1, 32'h21, 32'h55, 1'b1, 1'b0);
    ld_valid = 1'b1; ld_addr = 32'h20; #1;
    chk_fwd("stall_byte", 1'b0, 1'b1, 32'h0);
    tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk_fwd("stall_byte_only", 1'b0, 1'b1, 32'h0);
    tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk_fwd("stall_gone", 1'b0, 1'b0, 32'h0);

    // Head being dequeued this cycle still forwards.
    tick(1'b1, 32'h30, 32'hDEAD0030, 1'b0, 1'b0);
    ld_addr = 32'h30; dc_ack = 1'b1; #1;
    chk_fwd("fwd_head_deq", 1'b1, 1'b0, 32'hDEAD0030);
    tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    ld_valid = 1'b0;
    chk_level("head_deq");

    // Full with simultaneous store and ack: store rejected, count drops.
    for (int i = 0; i < 4; i++) tick(1'b1, 32'h40 + 32'(4 * i), 32'h4000 + 32'(i), 1'b0, 1'b0);
    chk_level("full2");
    tick(1'b1, 32'h50, 32'h5050, 1'b0, 1'b1);
    chk_level("full_ack");
    chk("full_ack_count", 64'(count), 64'(3));
    for (int i = 0; i < 6; i++) tick(1'b1, 32'h60 + 32'(4 * i), 32'h6000 + 32'(i), 1'b0, 1'b1);
    chk_level("wrap");
    for (int i = 0; i < 3; i++) tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk_level("wrap_drain");

    // Asynchronous reset mid-drain drops pending stores immediately.
    tick(1'b1, 32'h80, 32'h8080, 1'b0, 1'b0);
    tick(1'b1, 32'h84, 32'h8484, 1'b0, 1'b0);
    chk("pre_rst_dc_req", 64'(dc_req), 64'(1));
    #2;
    reset = 1'b1;
    sb.delete();
    #1;
    chk("arst_dc_req", 64'(dc_req), 64'(0));
    chk("arst_dc_addr", 64'(dc_addr), 64'(0));
    chk_level("arst");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk_level("post_rst");
    chk("post_rst_st_ready", 64'(st_ready), 64'(1));
    tick(1'b1, 32'h90, 32'h9090, 1'b0, 1'b0);
    chk("post_rst_dc_addr", 64'(dc_addr), 64'(32'h90));
    tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk_level("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
